// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle RV32I control path: state codes, opcodes,
// ALUOp/ALUControl codes and datapath selector encodings.
package multicycle_control_unit_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Decoder-field inputs and datapath control outputs of the multicycle control unit.
// master = control unit side, slave = datapath side.
interface multicycle_control_unit_if;
    logic [6:0] Opcode_i;
    logic [2:0] Funct3_i;
    logic       Funct7b5_i;
    logic       Zero_i;
    logic       PCWrite_o;
    logic       AdrSrc_o;
    logic       MemWrite_o;
    logic       IRWrite_o;
    logic       RegWrite_o;
    logic [1:0] ResultSrc_o;
    logic [1:0] ALUSrcA_o;
    logic [1:0] ALUSrcB_o;
    logic [1:0] ImmSrc_o;
    logic [2:0] ALUControl_o;
    logic [3:0] State_o;

    modport master (
        input  Opcode_i, Funct3_i, Funct7b5_i, Zero_i,
        output PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, RegWrite_o,
        output ResultSrc_o, ALUSrcA_o, ALUSrcB_o, ImmSrc_o, ALUControl_o, State_o
    );

    modport slave (
        output Opcode_i, Funct3_i, Funct7b5_i, Zero_i,
        input  PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, RegWrite_o,
        input  ResultSrc_o, ALUSrcA_o, ALUSrcB_o, ImmSrc_o, ALUControl_o, State_o
    );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU operation decode from ALUOp and instruction fields.
// Purely combinational, zero latency, no backpressure.
import multicycle_control_unit_pkg::*;

module alu_decoder (
    input  aluop_t     alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type with funct7[5] set is sub; addi ignores funct7b5.
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle RV32I datapath; only State_o is registered.
// Outputs follow state/decoder inputs in the same cycle; no backpressure.
import multicycle_control_unit_pkg::*;

module multicycle_control_unit (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_control_unit_if.master  ctrl
);
    state_t     state_q, state_d;
    aluop_t     alu_op;
    logic       pc_update, branch;
    logic       adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (ctrl.Opcode_i)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE:          state_d = EXECI;
                    OP_JAL:            state_d = JAL;
                    OP_BEQ:            state_d = BEQ;
                    default:           state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = ctrl.Opcode_i[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = MEMWB;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            JAL:      state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        alu_op     = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                pc_update  = 1'b1;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECR: begin
                alu_src_a = SRCA_REG;
                alu_op    = ALUOP_FUNCT;
            end
            ALUWB:    reg_write = 1'b1;
            EXECI: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            BEQ: begin
                alu_src_a = SRCA_REG;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (ctrl.Funct3_i),
        .op5         (ctrl.Opcode_i[5]),
        .funct7b5    (ctrl.Funct7b5_i),
        .alu_control (alu_control)
    );

    always_comb begin
        case (ctrl.Opcode_i)
            OP_STORE: ctrl.ImmSrc_o = IMM_S;
            OP_BEQ:   ctrl.ImmSrc_o = IMM_B;
            OP_JAL:   ctrl.ImmSrc_o = IMM_J;
            default:  ctrl.ImmSrc_o = IMM_I;
        endcase
    end

    // Write enables are held off while reset is asserted, whatever the state.
    assign ctrl.PCWrite_o    = ~reset & (pc_update | (branch & ctrl.Zero_i));
    assign ctrl.IRWrite_o    = ~reset & ir_write;
    assign ctrl.RegWrite_o   = ~reset & reg_write;
    assign ctrl.MemWrite_o   = ~reset & mem_write;
    assign ctrl.AdrSrc_o     = adr_src;
    assign ctrl.ResultSrc_o  = result_src;
    assign ctrl.ALUSrcA_o    = alu_src_a;
    assign ctrl.ALUSrcB_o    = alu_src_b;
    assign ctrl.ALUControl_o = alu_control;
    assign ctrl.State_o      = state_q;

endmodule
